mem_access_master: RTL and testbench

//  Initiator side of the CPU's single-port instruction/data RAM. Accepts

---
 rtl/mem_access_master.sv | 148 ++++++++++++++
 tb/tb_mem_access_master.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_master.sv
// mem_access_master: initiator for the CPU's single-port instruction/data RAM.
// It arbitrates instruction fetches and load/store requests, with loads and
// stores winning over fetches. Only one RAM access is in flight at a time.
// A fetch result goes to ir and a load result goes to mdr.
// Optional feature: define MEM_BOUND_CHK_EN to reject addresses that have any
// bit set above ADDR_W-1. A rejected access raises err together with its ack
// and never touches the RAM. When MEM_BOUND_CHK_EN is undefined, the upper
// address bits are ignored and addresses wrap.
module mem_access_master #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_pc,
  output logic              fetch_ack,
  output logic [DATA_W-1:0] ir,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [31:0]       data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_ack,
  output logic [DATA_W-1:0] mdr,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic                we_q, we_d;
  logic                fetch_q, fetch_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic [31:0]         req_addr;
  logic                out_of_range;

  // The load/store address takes priority whenever data_req is present.
  assign req_addr = data_req ? data_addr : fetch_pc;

`ifdef MEM_BOUND_CHK_EN
  assign out_of_range = |req_addr[31:ADDR_W];
`else
  logic unused_upper_bits;
  assign out_of_range      = 1'b0;
  assign unused_upper_bits = ^{fetch_pc[31:ADDR_W], data_addr[31:ADDR_W]};
`endif

  // Next-state and register-update logic for the access sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    we_d       = we_q;
    fetch_d    = fetch_q;
    err_d      = err_q;
    ir_d       = ir_q;
    mdr_d      = mdr_q;
    case (state_q)
      IDLE: begin
        if (data_req || fetch_req) begin
          fetch_d = !data_req;
          err_d   = out_of_range;
          if (out_of_range) begin
            we_d    = 1'b0;
            state_d = DONE;
          end else begin
            // A fetch is always treated as a read, whatever data_we says.
            we_d       = data_req && data_we;
            ram_addr_d = req_addr[ADDR_W-1:0];
            if (data_req) ram_din_d = data_wdata;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = we_q ? DONE : WAIT;
      end
      WAIT: begin
        if (cnt_q == CNT_W'(RD_LAT - 1)) begin
          if (fetch_q) ir_d = ram_dout;
          else         mdr_d = ram_dout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register. Reset clears the data registers as well, and it discards
  // any read that is still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      we_q       <= 1'b0;
      fetch_q    <= 1'b0;
      err_q      <= 1'b0;
      ir_q       <= '0;
      mdr_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      we_q       <= we_d;
      fetch_q    <= fetch_d;
      err_q      <= err_d;
      ir_q       <= ir_d;
      mdr_q      <= mdr_d;
    end
  end

  // ram_we is decoded from the current state. A store that is in ISSUE when
  // reset arrives still commits, because the RAM samples on that same edge.
  assign ram_we    = (state_q == ISSUE) && we_q;
  assign fetch_ack = (state_q == DONE) && fetch_q;
  assign data_ack  = (state_q == DONE) && !fetch_q;
  assign busy      = (state_q != IDLE);
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ir        = ir_q;
  assign mdr       = mdr_q;
`ifdef MEM_BOUND_CHK_EN
  assign err = (state_q == DONE) && err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_master.sv
// Testbench for mem_access_master with ADDR_W=9 and RD_LAT=1. It drives
// randomized fetch, load and store traffic, and checks the acknowledged
// results against a word-array reference model through a scoreboard queue.
module tb_mem_access_master;
  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req, data_req, data_we;
  logic [31:0]   fetch_pc, data_addr;
  logic [DW-1:0] data_wdata, ir, mdr, ram_din, ram_dout;
  logic          fetch_ack, data_ack, err, busy, ram_we;
  logic [AW-1:0] ram_addr;

  always #5 clk = ~clk;

  mem_access_master #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_ack(fetch_ack), .ir(ir),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_ack(data_ack), .mdr(mdr), .err(err),
    .busy(busy), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout)
  );

  function automatic logic [31:0] init_val(int a);
    return 32'h13579BDF ^ (32'(a) * 32'h01010033);
  endfunction

  // RAM with a read latency of one clock. A word reads as its initial
  // pattern until something writes it.
  logic [31:0] ram [512];
  bit          wr  [512];
  always @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr] <= ram_din;
      wr[ram_addr]  <= 1'b1;
    end
    ram_dout <= wr[ram_addr] ? ram[ram_addr] : init_val(int'(ram_addr));
  end

  typedef struct {
    bit          is_fetch;
    logic [31:0] ir;
    logic [31:0] mdr;
    bit          err;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [31:0] ref_mem [512];
  logic [31:0] m_ir, m_mdr;
  int          tests = 0;
  int          fails = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: apply the access to the word array, then queue the
  // expected register view that goes with the ack.
  function automatic void model(bit f, bit we, logic [31:0] a, logic [31:0] wd,
                                output int lat, output int wecnt);
    bit oor;
    int idx;
    oor = 1'b0;
`ifdef MEM_BOUND_CHK_EN
    oor = |a[31:9];
`endif
    idx   = int'(a % 512);
    wecnt = 0;
    if (oor) begin
      lat = 1;
    end else if (f) begin
      m_ir = ref_mem[idx];
      lat  = 3;
    end else if (we) begin
      ref_mem[idx] = wd;
      lat   = 2;
      wecnt = 1;
    end else begin
      m_mdr = ref_mem[idx];
      lat   = 3;
    end
    q.push_back('{f, m_ir, m_mdr, oor});
  endfunction

  // Monitor: every ack must match the oldest expectation in the queue.
  always @(negedge clk) begin
    if (fetch_ack || data_ack) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ack: got fetch_ack=%0b data_ack=%0b expected none at %0t",
                 fetch_ack, data_ack, $time);
      end else begin
        mon_e = q.pop_front();
        check("ack_kind", {31'b0, fetch_ack}, {31'b0, mon_e.is_fetch});
        check("ack_ir", ir, mon_e.ir);
        check("ack_mdr", mdr, mon_e.mdr);
        check("ack_err", {31'b0, err}, {31'b0, mon_e.err});
      end
    end
  end

  task automatic run_op(bit f, bit we, logic [31:0] a, logic [31:0] wd);
    int lat, exp_lat, exp_we, we_cnt, we_at;
    bit got;
    @(posedge clk); #1;
    if (f) begin
      fetch_req = 1'b1;
      fetch_pc  = a;
      data_we   = 1'($urandom);
    end else begin
      data_req   = 1'b1;
      data_we    = we;
      data_addr  = a;
      data_wdata = wd;
    end
    model(f, we, a, wd, exp_lat, exp_we);
    got = 1'b0; we_cnt = 0; we_at = -1; lat = -1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (ram_we) begin
        we_cnt++;
        we_at = n;
      end
      if ((f && fetch_ack) || (!f && data_ack)) begin
        got = 1'b1;
        lat = n;
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout: got no ack expected ack at cycle %0d", exp_lat);
    end else begin
      check("ack_latency", 32'(lat), 32'(exp_lat));
    end
    check("we_cycles", 32'(we_cnt), 32'(exp_we));
    if (exp_we != 0) check("we_cycle_pos", 32'(we_at), 32'd1);
    @(posedge clk); #1;
    fetch_req = 1'b0;
    data_req  = 1'b0;
  endtask

  initial begin
    int  l1, w1, l2, w2;
    bit  got_d, got_f;
    bit  f, we;
    logic [31:0] a;

    for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
    fetch_req = 0; data_req = 0; data_we = 0;
    fetch_pc = 0; data_addr = 0; data_wdata = 0;
    m_ir = 0; m_mdr = 0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ir", ir, 32'h0);
    check("rst_mdr", mdr, 32'h0);
    check("rst_acks", {30'b0, fetch_ack, data_ack}, 32'h0);
    check("rst_ram_we", {31'b0, ram_we}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_ram_addr", {23'b0, ram_addr}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Store an instruction word, fetch it, then store and load back.
    run_op(0, 1, 32'd5, 32'h8C010004);
    run_op(1, 0, 32'd5, 32'h0);
    run_op(0, 1, 32'h10, 32'hDEADBEEF);
    run_op(0, 0, 32'h10, 32'h0);

    // Simultaneous fetch and load: the load goes first.
    @(posedge clk); #1;
    fetch_req = 1'b1; fetch_pc = 32'd7;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h10;
    model(0, 0, 32'h10, 32'h0, l1, w1);
    model(1, 0, 32'd7, 32'h0, l2, w2);
    got_d = 0; got_f = 0;
    for (int n = 0; n < 30 && !got_f; n++) begin
      @(negedge clk);
      if (data_ack && !got_d) begin
        got_d = 1'b1;
        check("prio_data_lat", 32'(n), 32'd3);
        @(posedge clk); #1 data_req = 1'b0;
      end else if (fetch_ack) begin
        got_f = 1'b1;
        check("prio_fetch_lat", 32'(n), 32'd7);
      end
    end
    check("prio_both_acked", {30'b0, got_d, got_f}, 32'h3);
    @(posedge clk); #1;
    fetch_req = 1'b0; data_req = 1'b0;

    // Reset during WAIT of a load: the ack is dropped and the registers clear.
    @(posedge clk); #1;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h10;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst_wait_busy", {31'b0, busy}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0; data_req = 1'b0;
    m_ir = 0; m_mdr = 0;
    @(negedge clk);
    check("rst_mid_busy", {31'b0, busy}, 32'h0);
    check("rst_mid_mdr", mdr, 32'h0);
    check("rst_mid_ir", ir, 32'h0);
    repeat (4) @(negedge clk);

    // Reset while a store is in ISSUE: the write still lands in RAM.
    @(posedge clk); #1;
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h21; data_wdata = 32'h12345678;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst_store_we", {31'b0, ram_we}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0; data_req = 1'b0;
    ref_mem[9'h21] = 32'h12345678;
    run_op(0, 0, 32'h21, 32'h0);

    // Addresses beyond the RAM: wrap, or get rejected with err when bound checking is on.
    run_op(0, 0, 32'h200, 32'h0);
    run_op(1, 0, 32'h405, 32'h0);
    run_op(0, 1, 32'h8000_0003, 32'hCAFEF00D);
    run_op(0, 0, 32'h3, 32'h0);

    // Randomized traffic
    repeat (60) begin
      f  = ($urandom % 3) == 0;
      we = !f && (($urandom % 2) == 1);
      a  = 32'($urandom_range(0, 31));
      if (($urandom % 4) == 0) a = a | ($urandom << 9);
      run_op(f, we, a, $urandom);
    end

    repeat (5) @(posedge clk);
    check("queue_empty", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
